fifo_rd_ptr_empty: RTL and testbench

Read-side pointer and empty-flag generator for the dual-clock sample FIFO, the counterpart of the write-side full logic.
- Lives entirely in the read clock domain.
- Synchronises the write Gray pointer through two flops.
- Advances a binary/Gray read pointer on accepted reads and produces a registered, pessimistic empty flag.
- Exports the read Gray pointer for the write domain and the binary RAM read address.

---
 rtl/fifo_rd_ptr_empty.sv | 95 +++++++++
 tb/tb_fifo_rd_ptr_empty.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and empty-flag generator for the dual-clock sample FIFO.
// Optional macro FIFO_RD_LEVEL_EN adds the read-side fill level and almost-empty threshold.
module fifo_rd_ptr_empty #(
    parameter int ASIZE    = 3,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [ASIZE:0]   waddr_gray,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   raddr_gray,
    output logic             empty,
    output logic             underflow,
    output logic             almost_empty,
    output logic [ASIZE:0]   rlevel
);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbin_next;
    logic [ASIZE:0] rgray_next;
    logic [ASIZE:0] wg_s1;
    logic [ASIZE:0] wg_s2;
    logic           rd_ok;

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Two-flop synchroniser for the write Gray pointer; only wg_s2 is ever compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wg_s1 <= '0;
            wg_s2 <= '0;
        end else begin
            wg_s1 <= waddr_gray;
            wg_s2 <= wg_s1;
        end
    end

    assign rd_ok      = req & ~empty;
    assign rbin_next  = rbin + {{ASIZE{1'b0}}, rd_ok};
    assign rgray_next = bin2gray(rbin_next);
    assign raddr      = rbin[ASIZE-1:0];

    // Empty compares the next read pointer so the last read raises it with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin       <= '0;
            raddr_gray <= '0;
            empty      <= 1'b1;
            underflow  <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            raddr_gray <= rgray_next;
            empty      <= (rgray_next == wg_s2);
            if (req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [ASIZE:0] AE_THR = (ASIZE + 1)'(AE_LEVEL);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] level_next;

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wbin       = gray2bin(wg_s2);
    assign level_next = wbin - rbin_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rlevel       <= '0;
            almost_empty <= 1'b1;
        end else begin
            rlevel       <= level_next;
            almost_empty <= (level_next <= AE_THR);
        end
    end
`else
    assign rlevel       = '0;
    assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Directed bench for fifo_rd_ptr_empty; expected read addresses flow through a scoreboard queue.
// Level/almost-empty expectations follow FIFO_RD_LEVEL_EN when it is defined.
module tb_fifo_rd_ptr_empty;
    localparam int ASIZE    = 3;
    localparam int AE_LEVEL = 2;
    localparam int PMASK    = (1 << (ASIZE + 1)) - 1;

    logic             clk;
    logic             rst;
    logic             req;
    logic [ASIZE:0]   waddr_gray;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   raddr_gray;
    logic             empty;
    logic             underflow;
    logic             almost_empty;
    logic [ASIZE:0]   rlevel;

    int checks = 0;
    int errors = 0;
    int m_rbin = 0;
    int m_wbin = 0;
    logic m_uf = 1'b0;
    int exp_q[$];

    fifo_rd_ptr_empty #(.ASIZE(ASIZE), .AE_LEVEL(AE_LEVEL)) dut (
        .clk(clk), .rst(rst), .req(req), .waddr_gray(waddr_gray),
        .raddr(raddr), .raddr_gray(raddr_gray), .empty(empty),
        .underflow(underflow), .almost_empty(almost_empty), .rlevel(rlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ASIZE:0] gray(input int b);
        logic [ASIZE:0] x;
        x = (ASIZE + 1)'(b & PMASK);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lvl(input int lvl, input logic exp_empty);
`ifdef FIFO_RD_LEVEL_EN
        chk("rlevel", 32'(rlevel), 32'(lvl));
        chk("almost_empty", 32'(almost_empty), 32'(lvl <= AE_LEVEL));
`else
        chk("rlevel", 32'(rlevel), 32'd0);
        chk("almost_empty", 32'(almost_empty), 32'(exp_empty));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int wbin);
        m_wbin     = wbin;
        waddr_gray = gray(wbin);
    endtask

    task automatic settle();
        int lvl;
        repeat (3) tick();
        lvl = (m_wbin - m_rbin) & PMASK;
        chk("empty_settled", 32'(empty), 32'(lvl == 0));
        chk_lvl(lvl, lvl == 0);
    endtask

    task automatic read_n(input int n);
        int lvl;
        for (int i = 0; i < n; i++) exp_q.push_back((m_rbin + i) & ((1 << ASIZE) - 1));
        req = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("raddr", 32'(raddr), 32'(exp_q.pop_front()));
            tick();
            m_rbin = m_rbin + 1;
            lvl = (m_wbin - m_rbin) & PMASK;
            chk("raddr_gray", 32'(raddr_gray), 32'(gray(m_rbin)));
            chk("empty", 32'(empty), 32'(lvl == 0));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk_lvl(lvl, lvl == 0);
        end
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        waddr_gray = '0;
        #12;
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_raddr_gray", 32'(raddr_gray), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk_lvl(0, 1'b1);
        rst = 1'b0;
        tick();
        chk("idle_empty", 32'(empty), 32'd1);

        // One entry written: empty must fall exactly on the third edge.
        set_w(1);
        tick();
        chk("lat_edge1", 32'(empty), 32'd1);
        tick();
        chk("lat_edge2", 32'(empty), 32'd1);
        tick();
        chk("lat_edge3", 32'(empty), 32'd0);
        chk_lvl(1, 1'b0);

        // Drain three entries.
        set_w(3);
        settle();
        read_n(3);
        chk("drain_gray", 32'(raddr_gray), 32'd2);

        // Read while empty.
        req = 1'b1;
        chk("uf_before", 32'(underflow), 32'd0);
        tick();
        req = 1'b0;
        m_uf = 1'b1;
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_raddr_hold", 32'(raddr), 32'd3);
        chk("uf_gray_hold", 32'(raddr_gray), 32'(gray(3)));
        chk("uf_empty", 32'(empty), 32'd1);

        // Level 4 drained through the almost-empty threshold.
        set_w(7);
        settle();
        read_n(4);

        // Fill to full, drain to rbin=15, then write pointer wraps to 16.
        set_w(15);
        settle();
        read_n(8);
        set_w(16);
        settle();
        chk("wrap_gray_pre", 32'(raddr_gray), 32'd8);
        read_n(1);
        chk("wrap_gray_post", 32'(raddr_gray), 32'd0);
        chk("wrap_raddr", 32'(raddr), 32'd0);

        // Mid-run asynchronous reset with rbin=5 and one entry still pending.
        set_w(22);
        settle();
        read_n(5);
        chk("pre_rst_raddr", 32'(raddr), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_raddr", 32'(raddr), 32'd0);
        chk("arst_raddr_gray", 32'(raddr_gray), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_underflow", 32'(underflow), 32'd0);
        chk_lvl(0, 1'b1);
        waddr_gray = '0;
        #2;
        rst = 1'b0;
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
